fpu_addsub_sched: RTL
=====================

Name: fpu_addsub_sched

Overview:
- Two-requester scheduler that shares one combinational single-precision add/sub unit (addf/subf pair behind an external op mux) between two clients.
- Each client has a valid/ready request port. A single response port returns the result tagged with the requester ID.
- Round-robin arbitration, registered operand drive to the unit, programmable settle time, and response hold under backpressure.
- Sits between the integer/control pipeline and the float datapath.

Parameters:
- WIDTH, 32, operand/result width (IEEE-754 single).
- EXEC_CYCLES, 1, cycles the unit inputs are held stable before the result is sampled; legal range 1..15.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  requester 0 operation accepted this cycle.
- req0_op  in  1  0 = add, 1 = sub (a - b).
- req0_a  in  WIDTH  operand a.
- req0_b  in  WIDTH  operand b.
- req1_valid, req1_ready, req1_op, req1_a, req1_b: same as requester 0, for requester 1.
- fu_a  out  WIDTH  registered operand a to the shared unit.
- fu_b  out  WIDTH  registered operand b to the shared unit.
- fu_op  out  1  registered select for the external add/sub result mux.
- fu_s  in  WIDTH  result from the shared unit (combinational from fu_a/fu_b/fu_op).
- resp_valid  out  1  response available.
- resp_ready  in  1  consumer accepts the response.
- resp_id  out  1  requester that issued the operation.
- resp_data  out  WIDTH  registered result.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async, rst_n = 0):
  - state = IDLE; last_grant = 1, so req0 wins the first contention.
  - fu_a = fu_b = 0, fu_op = 0.
  - resp_valid = resp_id = 0, resp_data = 0, busy = 0, counter = 0.
  - Reset mid-operation abandons the operation; no response is produced.
- FSM states: IDLE, EXEC, DONE.
- IDLE:
  - grant = the only valid requester. If both are valid, grant = ~last_grant.
  - reqN_ready = (state == IDLE) && grant == N. This is combinational. The ungranted ready is 0.
  - ready must not depend on the requester's own valid except through the arbitration above. Requesters must not gate valid on ready.
  - On an edge with a valid&&ready handshake:
    - capture a/b/op into fu_a/fu_b/fu_op;
    - set grant_id = N;
    - load counter = EXEC_CYCLES-1;
    - go to EXEC.
  - With no valid request, stay in IDLE; fu_* hold their last values.
- EXEC:
  - fu_* held stable.
  - If counter != 0, decrement.
  - If counter == 0, on the next edge: resp_data = fu_s, resp_id = grant_id, resp_valid = 1, last_grant = grant_id, go to DONE.
  - Requests are ignored (ready = 0).
- DONE:
  - resp_valid/resp_id/resp_data held stable while resp_ready = 0, for an unbounded number of cycles.
  - On an edge with resp_valid && resp_ready: resp_valid = 0, go to IDLE.
  - No request is accepted in the same cycle as the response handshake.
- Latency: accept at edge k → resp_valid high after edge k + EXEC_CYCLES.
- Throughput: one operation per EXEC_CYCLES + 2 cycles minimum (accept, EXEC_CYCLES, and one IDLE cycle).
- Fairness: after req0 is served and both requesters remain valid, req1 is granted next, and vice versa. A lone requester is granted back-to-back.
- Requester valid dropping while not granted: no effect, nothing queued.
- Data rules:
  - The scheduler does no arithmetic; resp_data equals fu_s bit-exact as sampled at the capture edge.
  - A sub of equal operands returns whatever the unit produces (expected 0x00000000).
- No X on any output after reset.

Test Plan:
- Single add: req0 valid, op = 0, a = 0x3F800000 (1.0), b = 0x40000000 (2.0), EXEC_CYCLES = 1, resp_ready = 1.
  - Required: req0_ready high in the accept cycle.
  - Required: resp_valid one cycle after the accept edge with resp_data = 0x40400000 (3.0) and resp_id = 0.
  - Required: busy low again the cycle after the response handshake.
- Sub and zero result: req1 op = 1, a = 0x40400000, b = 0x3F800000 → resp_data = 0x40000000, resp_id = 1.
  - Then req1 op = 1, a = b = 0x40000000 → resp_data = 0x00000000.
- Contention, round-robin: both valid continuously with distinct operands, 4 operations.
  - Required grant order: 0, 1, 0, 1, with resp_id matching the order.
  - Required: the ungranted ready is never high while the other requester is granted.
- Backpressure: resp_ready held 0 for 5 cycles after resp_valid.
  - Required: resp_data/resp_id stable and both readys 0 for all 5 cycles.
  - Required: on the ready edge, resp_valid drops; the earliest next accept is one cycle later.
- Settle time: EXEC_CYCLES = 3; change an external fu_s model mid-EXEC.
  - Required: the sample is taken exactly at edge k+3; resp_valid rises after that edge, not before.
- Async reset mid-EXEC: assert rst_n = 0 between edges.
  - Required: outputs go to reset values immediately and no response follows.
  - Required: after release, a contended request grants req0 first.

Source files
------------

// File: rtl/fpu_addsub_sched.sv
// Two-client scheduler in front of one shared combinational add/sub unit.
// Round-robin grant, registered operand drive, programmable settle time,
// and a response register that holds under backpressure.
module fpu_addsub_sched #(
  parameter int WIDTH       = 32,
  parameter int EXEC_CYCLES = 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_req0_valid,
  output logic             o_req0_ready,
  input  logic             i_req0_op,
  input  logic [WIDTH-1:0] i_req0_a,
  input  logic [WIDTH-1:0] i_req0_b,
  input  logic             i_req1_valid,
  output logic             o_req1_ready,
  input  logic             i_req1_op,
  input  logic [WIDTH-1:0] i_req1_a,
  input  logic [WIDTH-1:0] i_req1_b,
  output logic [WIDTH-1:0] o_fu_a,
  output logic [WIDTH-1:0] o_fu_b,
  output logic             o_fu_op,
  input  logic [WIDTH-1:0] i_fu_s,
  output logic             o_resp_valid,
  input  logic             i_resp_ready,
  output logic             o_resp_id,
  output logic [WIDTH-1:0] o_resp_data,
  output logic             o_busy
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

  // Counter reload: EXEC spends EXEC_CYCLES edges, the last one samples fu_s.
  localparam logic [3:0] CNT_INIT = 4'(EXEC_CYCLES - 1);

  state_t           r_state;
  logic             r_last_grant;
  logic             r_grant_id;
  logic [3:0]       r_cnt;
  logic [WIDTH-1:0] r_fu_a;
  logic [WIDTH-1:0] r_fu_b;
  logic             r_fu_op;
  logic             r_resp_valid;
  logic             r_resp_id;
  logic [WIDTH-1:0] r_resp_data;

  logic             w_grant;
  logic             w_idle;
  logic             w_acc;

  // Contention flips against the last served client; a lone client always wins.
  assign w_grant      = (i_req0_valid && i_req1_valid) ? ~r_last_grant : i_req1_valid;
  assign w_idle       = (r_state == S_IDLE);
  assign o_req0_ready = w_idle && !w_grant;
  assign o_req1_ready = w_idle &&  w_grant;
  assign w_acc        = w_grant ? (i_req1_valid && o_req1_ready)
                                : (i_req0_valid && o_req0_ready);

  assign o_fu_a       = r_fu_a;
  assign o_fu_b       = r_fu_b;
  assign o_fu_op      = r_fu_op;
  assign o_resp_valid = r_resp_valid;
  assign o_resp_id    = r_resp_id;
  assign o_resp_data  = r_resp_data;
  assign o_busy       = !w_idle;

  // Accept -> settle -> sample -> hold response until consumed.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= S_IDLE;
      r_last_grant <= 1'b1;
      r_grant_id   <= 1'b0;
      r_cnt        <= '0;
      r_fu_a       <= '0;
      r_fu_b       <= '0;
      r_fu_op      <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_id    <= 1'b0;
      r_resp_data  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_acc) begin
            r_fu_a     <= w_grant ? i_req1_a  : i_req0_a;
            r_fu_b     <= w_grant ? i_req1_b  : i_req0_b;
            r_fu_op    <= w_grant ? i_req1_op : i_req0_op;
            r_grant_id <= w_grant;
            r_cnt      <= CNT_INIT;
            r_state    <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
          end else begin
            r_resp_data  <= i_fu_s;
            r_resp_id    <= r_grant_id;
            r_resp_valid <= 1'b1;
            r_last_grant <= r_grant_id;
            r_state      <= S_DONE;
          end
        end
        S_DONE: begin
          if (r_resp_valid && i_resp_ready) begin
            r_resp_valid <= 1'b0;
            r_state      <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
